// File: rtl/sy_pkg.sv
// Shared dispatch types for the sy pipeline.
// Provides the decoded-instruction bundle and issue target enum.
package sy_pkg;

    localparam int DIS_NUM_TGT = 3;

    typedef enum logic [1:0] {
        TO_EXU = 2'd0,
        TO_LSU = 2'd1,
        TO_CSR = 2'd2
    } issue_type_e;

    typedef struct packed {
        issue_type_e issue_type;
        logic [31:0] pc;
        logic [31:0] instr;
    } dispatch_t;

endpackage

// File: rtl/sy_ppl_dis_buf_if.sv
// Dispatch buffer bus: decode->dispatch push, dispatch->target issue,
// and dispatch->ROB allocate handshakes. slave = buffer, master = env.
interface sy_ppl_dis_buf_if
    import sy_pkg::*;
#(
    parameter int NUM_TGT = DIS_NUM_TGT
);

    logic               dec_dis__vld_i;
    logic               dis_dec__rdy_o;
    dispatch_t          dec_dis__data_i;
    logic [NUM_TGT-1:0] dis_tgt__vld_o;
    logic [NUM_TGT-1:0] tgt_dis__rdy_i;
    dispatch_t          dis_tgt__data_o;
    logic               dis_rob__vld_o;
    logic               rob_dis__rdy_i;

    modport slave (
        input  dec_dis__vld_i,
        input  dec_dis__data_i,
        input  tgt_dis__rdy_i,
        input  rob_dis__rdy_i,
        output dis_dec__rdy_o,
        output dis_tgt__vld_o,
        output dis_tgt__data_o,
        output dis_rob__vld_o
    );

    modport master (
        output dec_dis__vld_i,
        output dec_dis__data_i,
        output tgt_dis__rdy_i,
        output rob_dis__rdy_i,
        input  dis_dec__rdy_o,
        input  dis_tgt__vld_o,
        input  dis_tgt__data_o,
        input  dis_rob__vld_o
    );

endinterface

// File: rtl/sy_ppl_dis_buf.sv
// In-order dispatch buffer: circular FIFO between decode and issue.
// Ports: clk_i, rst_i (async, active-low), flush_i, bus (slave),
// dis_cnt_o (occupancy), dis_stall_cnt_o (saturating stall cycles).
module sy_ppl_dis_buf
    import sy_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int NUM_TGT = DIS_NUM_TGT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    sy_ppl_dis_buf_if.slave       bus,
    output logic [$clog2(DEPTH):0] dis_cnt_o,
    output logic [31:0]           dis_stall_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_stall;
    dispatch_t     r_mem [DEPTH];

    dispatch_t          w_head;
    logic [1:0]         w_sel;
    logic [NUM_TGT-1:0] w_tgt_hit;
    logic               w_tgt_rdy;
    logic               w_nempty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_stall_inc;

    assign w_head   = r_mem[r_rd_ptr];
    assign w_sel    = w_head.issue_type;
    assign w_nempty = (r_cnt != '0);
    assign w_full   = (r_cnt == CW'(DEPTH));

    // Decode the head's target; an out-of-range selector matches no
    // target, so it never sees a ready and simply sits at the head.
    always_comb begin
        w_tgt_hit = '0;
        w_tgt_rdy = 1'b0;
        for (int t = 0; t < NUM_TGT; t++) begin
            if (32'(w_sel) == 32'(t)) begin
                w_tgt_hit[t] = 1'b1;
                w_tgt_rdy    = bus.tgt_dis__rdy_i[t];
            end
        end
    end

    // Ready depends only on registered occupancy, so a full buffer
    // refuses a push even in a cycle where the head pops.
    assign w_push = bus.dec_dis__vld_i && !w_full && !flush_i;
    assign w_pop  = w_nempty && !flush_i
                 && bus.rob_dis__rdy_i && w_tgt_rdy;

    assign w_stall_inc = w_nempty && !flush_i && !w_pop;

    assign bus.dis_dec__rdy_o  = !w_full;
    assign bus.dis_tgt__vld_o  = {NUM_TGT{w_pop}} & w_tgt_hit;
    assign bus.dis_rob__vld_o  = w_pop;
    assign bus.dis_tgt__data_o = w_head;

    assign dis_cnt_o       = r_cnt;
    assign dis_stall_cnt_o = r_stall;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Stall count survives flush; only reset clears it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall <= '0;
        end else if (w_stall_inc && (r_stall != '1)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.dec_dis__data_i;
    end

endmodule

// File: tb/tb_sy_ppl_dis_buf.sv
// Directed bench for sy_ppl_dis_buf (DEPTH=4, three targets).
// Hand-computed expectations checked with immediate assertions.
module tb_sy_ppl_dis_buf;
    import sy_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [2:0]  cnt;
    logic [31:0] stall;

    int n_vec = 0;
    int n_err = 0;

    sy_ppl_dis_buf_if #(.NUM_TGT(3)) bus ();

    sy_ppl_dis_buf #(
        .DEPTH   (4),
        .NUM_TGT (3)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .flush_i         (flush),
        .bus             (bus.slave),
        .dis_cnt_o       (cnt),
        .dis_stall_cnt_o (stall)
    );

    always #5 clk = ~clk;

    function automatic dispatch_t mk(input logic [1:0] t,
                                     input logic [31:0] pc);
        return dispatch_t'({t, pc, ~pc});
    endfunction

    function automatic logic [63:0] oh(input int t);
        return 64'(1) << t;
    endfunction

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tick(input logic [1:0] t, input logic [31:0] pc);
        bus.dec_dis__vld_i  = 1'b1;
        bus.dec_dis__data_i = mk(t, pc);
        tick();
        bus.dec_dis__vld_i  = 1'b0;
    endtask

    initial begin
        rst   = 1'b0;
        flush = 1'b0;
        bus.dec_dis__vld_i  = 1'b0;
        bus.dec_dis__data_i = '0;
        bus.tgt_dis__rdy_i  = 3'b000;
        bus.rob_dis__rdy_i  = 1'b0;

        // reset state
        tick();
        chk("rst_cnt",   64'(cnt), 64'd0);
        chk("rst_rdy",   64'(bus.dis_dec__rdy_o), 64'd1);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_tvld",  64'(bus.dis_tgt__vld_o), 64'd0);
        chk("rst_rvld",  64'(bus.dis_rob__vld_o), 64'd0);
        rst = 1'b1;

        // fill with nothing ready
        push_tick(2'd1, 32'h100);
        push_tick(2'd0, 32'h104);
        push_tick(2'd2, 32'h108);
        push_tick(2'd0, 32'h10c);
        chk("A_cnt",   64'(cnt), 64'd4);
        chk("A_rdy",   64'(bus.dis_dec__rdy_o), 64'd0);
        chk("A_stall", 64'(stall), 64'd3);
        chk("A_tvld",  64'(bus.dis_tgt__vld_o), 64'd0);
        chk("A_head",  64'(bus.dis_tgt__data_o.pc), 64'h100);

        // LSU head only issues on its own ready
        bus.tgt_dis__rdy_i = 3'b001;
        bus.rob_dis__rdy_i = 1'b1;
        #1;
        chk("B_tvld0", 64'(bus.dis_tgt__vld_o), 64'd0);
        chk("B_rvld0", 64'(bus.dis_rob__vld_o), 64'd0);
        bus.tgt_dis__rdy_i = 3'b101;
        #1;
        chk("B_tvld1", 64'(bus.dis_tgt__vld_o), 64'd0);
        tick();
        chk("B_stall", 64'(stall), 64'd4);
        chk("B_cnt",   64'(cnt), 64'd4);

        // full: pop and refused push in the same cycle
        bus.tgt_dis__rdy_i  = 3'b010;
        bus.dec_dis__vld_i  = 1'b1;
        bus.dec_dis__data_i = mk(2'd0, 32'h110);
        #1;
        chk("C_tvld", 64'(bus.dis_tgt__vld_o), 64'h2);
        chk("C_rvld", 64'(bus.dis_rob__vld_o), 64'd1);
        chk("C_head", 64'(bus.dis_tgt__data_o.pc), 64'h100);
        chk("C_rdy",  64'(bus.dis_dec__rdy_o), 64'd0);
        tick();
        chk("C_cnt3",  64'(cnt), 64'd3);
        chk("C_rdy1",  64'(bus.dis_dec__rdy_o), 64'd1);
        chk("C_head2", 64'(bus.dis_tgt__data_o.pc), 64'h104);
        chk("C_tvld2", 64'(bus.dis_tgt__vld_o), 64'd0);
        chk("C_stall", 64'(stall), 64'd4);
        tick();
        bus.dec_dis__vld_i = 1'b0;
        chk("C_cnt4",   64'(cnt), 64'd4);
        chk("C_stall2", 64'(stall), 64'd5);

        // ROB gate, then drain in order
        bus.tgt_dis__rdy_i = 3'b111;
        bus.rob_dis__rdy_i = 1'b0;
        #1;
        chk("D_rob_tvld", 64'(bus.dis_tgt__vld_o), 64'd0);
        chk("D_rob_rvld", 64'(bus.dis_rob__vld_o), 64'd0);
        bus.rob_dis__rdy_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("D_pc", 64'(bus.dis_tgt__data_o.pc), 64'(32'h104 + 4 * i));
            chk("D_tvld", 64'(bus.dis_tgt__vld_o), oh(i == 1 ? 2 : 0));
            tick();
        end
        chk("D_cnt",   64'(cnt), 64'd0);
        chk("D_stall", 64'(stall), 64'd5);
        chk("D_tvld0", 64'(bus.dis_tgt__vld_o), 64'd0);

        // ten back-to-back, all ready
        for (int k = 0; k < 10; k++) begin
            bus.dec_dis__vld_i  = 1'b1;
            bus.dec_dis__data_i = mk(2'(k % 3), 32'h200 + 32'(4 * k));
            #1;
            if (k == 0) begin
                chk("E_nobyp", 64'(bus.dis_tgt__vld_o), 64'd0);
            end else begin
                chk("E_pc", 64'(bus.dis_tgt__data_o.pc),
                    64'(32'h200 + 4 * (k - 1)));
                chk("E_tvld", 64'(bus.dis_tgt__vld_o), oh((k - 1) % 3));
                chk("E_cnt", 64'(cnt), 64'd1);
            end
            tick();
        end
        bus.dec_dis__vld_i = 1'b0;
        #1;
        chk("E_last_pc",   64'(bus.dis_tgt__data_o.pc), 64'h224);
        chk("E_last_tvld", 64'(bus.dis_tgt__vld_o), 64'h1);
        tick();
        chk("E_cnt0",  64'(cnt), 64'd0);
        chk("E_stall", 64'(stall), 64'd5);

        // flush with three entries and a concurrent push
        bus.tgt_dis__rdy_i = 3'b000;
        bus.rob_dis__rdy_i = 1'b0;
        push_tick(2'd0, 32'h300);
        push_tick(2'd1, 32'h304);
        push_tick(2'd2, 32'h308);
        chk("F_cnt3",  64'(cnt), 64'd3);
        chk("F_stall", 64'(stall), 64'd7);
        flush = 1'b1;
        bus.dec_dis__vld_i  = 1'b1;
        bus.dec_dis__data_i = mk(2'd0, 32'h30c);
        bus.tgt_dis__rdy_i  = 3'b111;
        bus.rob_dis__rdy_i  = 1'b1;
        #1;
        chk("F_tvld", 64'(bus.dis_tgt__vld_o), 64'd0);
        chk("F_rvld", 64'(bus.dis_rob__vld_o), 64'd0);
        tick();
        flush = 1'b0;
        bus.dec_dis__vld_i = 1'b0;
        #1;
        chk("F_cnt0",   64'(cnt), 64'd0);
        chk("F_rdy",    64'(bus.dis_dec__rdy_o), 64'd1);
        chk("F_tvld0",  64'(bus.dis_tgt__vld_o), 64'd0);
        chk("F_stall2", 64'(stall), 64'd7);

        // illegal selector holds the head and stalls
        push_tick(2'd3, 32'h400);
        #1;
        chk("G_cnt",  64'(cnt), 64'd1);
        chk("G_head", 64'(bus.dis_tgt__data_o.pc), 64'h400);
        chk("G_tvld", 64'(bus.dis_tgt__vld_o), 64'd0);
        chk("G_rvld", 64'(bus.dis_rob__vld_o), 64'd0);
        tick();
        chk("G_cnt1",  64'(cnt), 64'd1);
        chk("G_stall", 64'(stall), 64'd8);

        // asynchronous reset mid-stream
        bus.tgt_dis__rdy_i = 3'b000;
        bus.rob_dis__rdy_i = 1'b0;
        push_tick(2'd0, 32'h404);
        chk("H_cnt2",  64'(cnt), 64'd2);
        chk("H_stall", 64'(stall), 64'd9);
        #2;
        rst = 1'b0;
        #1;
        chk("H_cnt0",  64'(cnt), 64'd0);
        chk("H_stal0", 64'(stall), 64'd0);
        chk("H_rdy",   64'(bus.dis_dec__rdy_o), 64'd1);
        bus.tgt_dis__rdy_i = 3'b111;
        bus.rob_dis__rdy_i = 1'b1;
        #1;
        chk("H_tvld", 64'(bus.dis_tgt__vld_o), 64'd0);
        chk("H_rvld", 64'(bus.dis_rob__vld_o), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("H_cnt_post", 64'(cnt), 64'd0);
        push_tick(2'd1, 32'h500);
        chk("H_tvld2", 64'(bus.dis_tgt__vld_o), 64'h2);
        chk("H_pc2",   64'(bus.dis_tgt__data_o.pc), 64'h500);
        tick();
        chk("H_cnt_end", 64'(cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
